pixel_readout_buffer: RTL and testbench

//  Downstream consumer of the pixel array top. Drives its read_data/data_ready

---
 rtl/pixel_readout_buffer_pkg.sv | 19 +
 rtl/pixel_readout_buffer_if.sv | 26 ++
 rtl/pixel_readout_buffer_sync_fifo.sv | 64 ++++++
 rtl/pixel_readout_buffer.sv | 131 +++++++++++++
 tb/tb_pixel_readout_buffer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_readout_buffer_pkg.sv
// Shared types for the pixel readout buffer: FIFO word layout and read FSM states.
package pixel_readout_buffer_pkg;

  localparam int unsigned PixelW = 8;

  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [PixelW-1:0] data;
  } pix_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSpace,
    StRead,
    StClose
  } rd_state_t;

endpackage

// File: rtl/pixel_readout_buffer_if.sv
// Outgoing pixel stream: valid/ready handshake with start/end-of-frame tags.
interface pixel_readout_buffer_if;

  logic [pixel_readout_buffer_pkg::PixelW-1:0] m_data;
  logic                                        m_valid;
  logic                                        m_ready;
  logic                                        m_sof;
  logic                                        m_eof;

  modport master (
    output m_data,
    output m_valid,
    output m_sof,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_sof,
    input  m_eof,
    output m_ready
  );

endinterface

// File: rtl/pixel_readout_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; writes while full and reads while empty are ignored.
module pixel_readout_buffer_sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [Width-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [Width-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_ok, rd_ok;

  // Full/empty come from the pre-edge count, so a write into a full FIFO is
  // rejected even if a read frees a slot on the same edge.
  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pixel_readout_buffer.sv
// Reads whole frames from the pixel array, tags first/last pixels and re-emits them
// through a FIFO as a valid/ready stream; tracks completed frames and frame errors.
module pixel_readout_buffer
  import pixel_readout_buffer_pkg::*;
#(
  parameter int unsigned NumPixels = 16,
  parameter int unsigned FifoDepth = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_ready,
  input  logic                        data_out_valid,
  input  logic [PixelW-1:0]           data_out,
  output logic                        read_data,
  pixel_readout_buffer_if.master      strm,
  output logic [15:0]                 frame_count,
  output logic                        frame_err
);

  localparam int unsigned CntW    = $clog2(FifoDepth) + 1;
  localparam int unsigned PixCntW = $clog2(NumPixels);

  rd_state_t          state_q, state_d;
  logic [PixCntW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               frame_err_q, frame_err_d;

  logic               fifo_wr, fifo_full, fifo_empty;
  logic [CntW-1:0]    fifo_count, free;
  pix_word_t          wr_word, rd_word;
  logic               space_ok, is_eof, eof_wr;

  assign free     = CntW'(FifoDepth) - fifo_count;
  assign space_ok = (free >= CntW'(NumPixels));
  assign is_eof   = (pix_cnt_q == PixCntW'(NumPixels - 1));
  assign fifo_wr  = (state_q == StRead) && data_out_valid;
  assign eof_wr   = fifo_wr && is_eof;

  always_comb begin
    wr_word.sof  = (pix_cnt_q == '0);
    wr_word.eof  = is_eof;
    wr_word.data = data_out;
  end

  pixel_readout_buffer_sync_fifo #(
    .Width($bits(pix_word_t)),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (wr_word),
    .rd_en   (strm.m_ready),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign strm.m_valid = !fifo_empty;
  assign strm.m_data  = rd_word.data;
  assign strm.m_sof   = rd_word.sof;
  assign strm.m_eof   = rd_word.eof;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (data_ready) state_d = space_ok ? StRead : StWaitSpace;
      end
      StWaitSpace: begin
        if (!data_ready) begin
          state_d = StIdle;
        end else if (space_ok) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (eof_wr || !data_ready) state_d = StClose;
      end
      StClose: begin
        if (!data_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign read_data = (state_q == StRead);

  // A frame ending without its last pixel, pixels past the last one, and
  // writes into a full FIFO all latch the sticky error.
  always_comb begin
    pix_cnt_d     = '0;
    frame_count_d = frame_count_q;
    frame_err_d   = frame_err_q;
    if (state_q == StRead) begin
      pix_cnt_d = pix_cnt_q;
      if (data_out_valid) begin
        pix_cnt_d = pix_cnt_q + PixCntW'(1);
        if (fifo_full) frame_err_d = 1'b1;
        if (is_eof) frame_count_d = frame_count_q + 16'd1;
      end
      if (!eof_wr && !data_ready) frame_err_d = 1'b1;
    end
    if ((state_q == StClose) && data_out_valid) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame_count = frame_count_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: pixel-array model, stream scoreboard, stall checks.
module tb_pixel_readout_buffer;
  import pixel_readout_buffer_pkg::*;

  localparam int unsigned NumPixels = 16;
  localparam int unsigned FifoDepth = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_ready;
  logic        data_out_valid;
  logic [7:0]  data_out;
  logic        read_data;
  logic [15:0] frame_count;
  logic        frame_err;

  pixel_readout_buffer_if strm ();

  pixel_readout_buffer #(
    .NumPixels(NumPixels),
    .FifoDepth(FifoDepth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_ready     (data_ready),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .read_data      (read_data),
    .strm           (strm),
    .frame_count    (frame_count),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        passes = 0;
  int        fails = 0;
  int        popped = 0;
  int        ready_mode = 1;  // 0 stall, 1 always ready, 2 random
  pix_word_t exp_q[$];
  logic      stalled = 1'b0;
  logic [9:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    strm.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) strm.m_ready = 1'($urandom_range(0, 1));
      else strm.m_ready = (ready_mode == 1);
    end
  end

  // Stream monitor: scoreboard pop on each transfer, hold check on each stall.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_hold", 32'({strm.m_valid, strm.m_sof, strm.m_eof, strm.m_data}),
            32'({1'b1, held}));
      end
      if (strm.m_valid && strm.m_ready) begin
        popped++;
        chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          pix_word_t e;
          e = exp_q.pop_front();
          chk("stream_word", 32'({strm.m_sof, strm.m_eof, strm.m_data}), 32'(e));
        end
      end
      stalled = strm.m_valid && !strm.m_ready;
      held    = {strm.m_sof, strm.m_eof, strm.m_data};
    end
  end

  task automatic apply_reset();
    reset          = 1'b1;
    data_ready     = 1'b0;
    data_out_valid = 1'b0;
    data_out       = 8'h00;
    step();
    step();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic start_frame(input int bound);
    int n;
    n = 0;
    data_ready = 1'b1;
    do begin
      step();
      n++;
    end while (!read_data && n < bound);
    chk("read_grant", 32'(read_data), 32'd1);
  endtask

  // Bytes beyond the frame length are expected to be dropped by the DUT.
  task automatic send_bytes(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          data_out_valid = 1'b0;
          step();
        end
      end
      b              = 8'(base + i);
      data_out_valid = 1'b1;
      data_out       = b;
      if (i < int'(NumPixels)) begin
        exp_q.push_back('{sof: (i == 0), eof: (i == int'(NumPixels) - 1), data: b});
      end
      step();
    end
    data_out_valid = 1'b0;
  endtask

  task automatic end_frame();
    data_ready = 1'b0;
    step();
    step();
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    apply_reset();
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_m_valid", 32'(strm.m_valid), 32'd0);
    chk("rst_m_data", 32'(strm.m_data), 32'd0);
    chk("rst_sof_eof", 32'({strm.m_sof, strm.m_eof}), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);

    // Basic frame, read_data one cycle after data_ready.
    ready_mode = 1;
    start_frame(1);
    send_bytes(16, 0, 1'b0);
    end_frame();
    wait_drain(100);
    chk("t1_frame_count", 32'(frame_count), 32'd1);
    chk("t1_frame_err", 32'(frame_err), 32'd0);

    // Two frames fill the FIFO; the third waits for 16 free entries.
    ready_mode = 0;
    step();
    start_frame(4);
    send_bytes(16, 8'h20, 1'b0);
    end_frame();
    start_frame(4);
    send_bytes(16, 8'h40, 1'b0);
    end_frame();
    chk("t2_full_valid", 32'(strm.m_valid), 32'd1);
    data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_wait_space", 32'(read_data), 32'd0);
    end
    base       = popped;
    ready_mode = 1;
    n          = 0;
    while (!read_data && n < 100) begin
      step();
      n++;
    end
    chk("t2_read_grant", 32'(read_data), 32'd1);
    chk("t2_drained_first", 32'((popped - base) >= 16 && (popped - base) <= 18), 32'd1);
    send_bytes(16, 8'h60, 1'b0);
    end_frame();
    wait_drain(200);
    chk("t2_frame_count", 32'(frame_count), 32'd4);
    chk("t2_frame_err", 32'(frame_err), 32'd0);

    // Short frame: 10 bytes then data_ready drops.
    start_frame(4);
    send_bytes(10, 8'h80, 1'b0);
    end_frame();
    wait_drain(100);
    step();
    chk("t3_no_extra", 32'(strm.m_valid), 32'd0);
    chk("t3_frame_count", 32'(frame_count), 32'd4);
    chk("t3_frame_err", 32'(frame_err), 32'd1);

    // Long frame: 18 bytes, last two dropped.
    apply_reset();
    start_frame(4);
    send_bytes(18, 8'hA0, 1'b0);
    end_frame();
    wait_drain(100);
    step();
    chk("t4_no_extra", 32'(strm.m_valid), 32'd0);
    chk("t4_frame_count", 32'(frame_count), 32'd1);
    chk("t4_frame_err", 32'(frame_err), 32'd1);

    // 100 frames with random backpressure and input gaps.
    apply_reset();
    ready_mode = 2;
    for (int f = 0; f < 100; f++) begin
      start_frame(400);
      send_bytes(16, f * 3, 1'b1);
      end_frame();
    end
    wait_drain(2000);
    chk("t5_frame_count", 32'(frame_count), 32'd100);
    chk("t5_frame_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    apply_reset();
    ready_mode = 1;
    start_frame(4);
    send_bytes(5, 8'hC0, 1'b0);
    reset      = 1'b1;
    data_ready = 1'b0;
    step();
    chk("t6_read_data", 32'(read_data), 32'd0);
    chk("t6_m_valid", 32'(strm.m_valid), 32'd0);
    chk("t6_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    step();
    start_frame(4);
    send_bytes(16, 8'hD0, 1'b0);
    end_frame();
    wait_drain(100);
    chk("t6_after_count", 32'(frame_count), 32'd1);
    chk("t6_after_err", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
